// File: rtl/iomem_pwm_gpio.sv
// Memory-mapped GPIO and multi-channel PWM peripheral on the picorv32 iomem bus.
// PERIOD/DUTY writes go to shadows and reach the counters only at a period boundary.
module iomem_pwm_gpio #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_WIDTH = 16,
  parameter logic [23:0] BASE_ADDR = 24'h030003
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic [31:0]       gpio_out,
  input  logic [31:0]       gpio_in,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [31:0] LP_CNT_MASK  = 32'((64'd1 << CNT_WIDTH) - 64'd1);
  localparam logic [31:0] LP_CTRL_MASK = 32'((64'd1 << NUM_CH) - 64'd1);

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic                 r_ready;
  logic [31:0]          r_rdata;
  logic [31:0]          r_gpio_out;
  logic [31:0]          r_gpio_s1;
  logic [31:0]          r_gpio_s2;
  logic [31:0]          r_ctrl;
  logic [31:0]          r_per_sh  [NUM_CH];
  logic [31:0]          r_duty_sh [NUM_CH];
  logic [CNT_WIDTH-1:0] r_aper    [NUM_CH];
  logic [CNT_WIDTH-1:0] r_aduty   [NUM_CH];
  logic [CNT_WIDTH-1:0] r_cnt     [NUM_CH];
  logic [NUM_CH-1:0]    r_pwm;

  logic        w_sel;
  logic        w_wr;
  logic        w_rd;
  logic        w_aligned;
  logic [5:0]  w_widx;
  logic [31:0] w_rmux;
  logic [31:0] w_wmerge;

  assign w_sel     = iomem_valid && !r_ready && (iomem_addr[31:8] == BASE_ADDR);
  assign w_wr      = w_sel && (iomem_wstrb != 4'b0000);
  assign w_rd      = w_sel && (iomem_wstrb == 4'b0000);
  // Unaligned byte offsets are treated as unmapped.
  assign w_aligned = (iomem_addr[1:0] == 2'b00);
  assign w_widx    = iomem_addr[7:2];

  always_comb begin
    w_rmux = '0;
    if (w_aligned) begin
      case (w_widx)
        6'd0:    w_rmux = r_gpio_out;
        6'd1:    w_rmux = r_gpio_s2;
        6'd2:    w_rmux = r_ctrl;
        default: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (w_widx == 6'(4 + 2*c)) w_rmux = r_per_sh[c];
            if (w_widx == 6'(5 + 2*c)) w_rmux = r_duty_sh[c];
          end
        end
      endcase
    end
  end

  // Current value of the addressed register with the enabled byte lanes replaced.
  assign w_wmerge = f_merge(w_rmux, iomem_wdata, iomem_wstrb);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready    <= 1'b0;
      r_rdata    <= '0;
      r_gpio_out <= '0;
      r_ctrl     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_per_sh[c]  <= '0;
        r_duty_sh[c] <= '0;
      end
    end else begin
      r_ready <= w_sel;
      r_rdata <= w_rd ? w_rmux : '0;
      if (w_wr && w_aligned) begin
        if (w_widx == 6'd0) r_gpio_out <= w_wmerge;
        if (w_widx == 6'd2) r_ctrl     <= w_wmerge & LP_CTRL_MASK;
        for (int c = 0; c < NUM_CH; c++) begin
          if (w_widx == 6'(4 + 2*c)) r_per_sh[c]  <= w_wmerge & LP_CNT_MASK;
          if (w_widx == 6'(5 + 2*c)) r_duty_sh[c] <= w_wmerge & LP_CNT_MASK;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gpio_s1 <= '0;
      r_gpio_s2 <= '0;
    end else begin
      r_gpio_s1 <= gpio_in;
      r_gpio_s2 <= r_gpio_s1;
    end
  end

  // Shadows are sampled with their pre-edge value, so a write landing on a
  // boundary edge is picked up only at the following boundary.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pwm <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_aper[c]  <= '0;
        r_aduty[c] <= '0;
        r_cnt[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!r_ctrl[c]) begin
          r_cnt[c]   <= '0;
          r_pwm[c]   <= 1'b0;
          r_aper[c]  <= r_per_sh[c][CNT_WIDTH-1:0];
          r_aduty[c] <= r_duty_sh[c][CNT_WIDTH-1:0];
        end else begin
          r_pwm[c] <= (r_cnt[c] < r_aduty[c]);
          if (r_cnt[c] == r_aper[c]) begin
            r_cnt[c]   <= '0;
            r_aper[c]  <= r_per_sh[c][CNT_WIDTH-1:0];
            r_aduty[c] <= r_duty_sh[c][CNT_WIDTH-1:0];
          end else begin
            r_cnt[c] <= r_cnt[c] + 1'b1;
          end
        end
      end
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign gpio_out    = r_gpio_out;
  assign pwm_out     = r_pwm;

endmodule

// File: tb/tb_iomem_pwm_gpio.sv
// Self-checking bench for iomem_pwm_gpio: register vector table, scoreboarded
// reads, and hand-timed PWM, boundary, reset and decode sequences.
module tb_iomem_pwm_gpio;

  localparam int          NUM_CH = 4;
  localparam logic [31:0] BASE   = 32'h0300_0300;
  localparam logic [31:0] GPIN   = 32'h5A5A_1234;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              iomem_valid = 1'b0;
  logic              iomem_ready;
  logic [3:0]        iomem_wstrb = 4'b0000;
  logic [31:0]       iomem_addr = '0;
  logic [31:0]       iomem_wdata = '0;
  logic [31:0]       iomem_rdata;
  logic [31:0]       gpio_out;
  logic [31:0]       gpio_in = GPIN;
  logic [NUM_CH-1:0] pwm_out;

  iomem_pwm_gpio #(
    .NUM_CH   (NUM_CH),
    .CNT_WIDTH(16),
    .BASE_ADDR(24'h030003)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .gpio_out   (gpio_out),
    .gpio_in    (gpio_in),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  off;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] q_exp [$];
  string       q_nm  [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Call with the clock away from its rising edge; returns 1 time unit after ready is seen.
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                      output logic [31:0] rd, output bit ok);
    iomem_addr  = addr;
    iomem_wdata = wd;
    iomem_wstrb = ws;
    iomem_valid = 1'b1;
    ok = 1'b0;
    rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (iomem_ready) begin
        ok = 1'b1;
        rd = iomem_rdata;
        break;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL xfer_timeout: addr 0x%08h got no ready within 8 cycles", addr);
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] rd;
    bit ok;
    xfer(BASE + 32'(off), wd, ws, rd, ok);
  endtask

  task automatic rd_check(input logic [7:0] off, input logic [31:0] exp, input string nm);
    logic [31:0] rd;
    logic [31:0] e;
    string n;
    bit ok;
    q_exp.push_back(exp);
    q_nm.push_back(nm);
    xfer(BASE + 32'(off), 32'h0, 4'b0000, rd, ok);
    e = q_exp.pop_front();
    n = q_nm.pop_front();
    if (ok) begin
      chk(n, rd, e);
      @(posedge clk);
      #1;
      chk({n, "_ready_width"}, 32'(iomem_ready), 32'd0);
    end
  endtask

  task automatic pwm_const(input logic expb, input int settle, input int n, input string nm);
    repeat (settle) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk(nm, 32'(pwm_out), {31'b0, expb});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h00, 32'h0000_00A5, 4'b0001, 32'h0000_00A5, "gpio_lane0"};
    vecs[1]  = '{8'h00, 32'hDEAD_BEEF, 4'b1010, 32'hDE00_BEA5, "gpio_lanes"};
    vecs[2]  = '{8'h08, 32'hFFFF_FFFF, 4'b1111, 32'h0000_000F, "ctrl_mask"};
    vecs[3]  = '{8'h10, 32'h1234_5678, 4'b1111, 32'h0000_5678, "period0_trunc"};
    vecs[4]  = '{8'h14, 32'hFFFF_FFFF, 4'b0100, 32'h0000_0000, "duty0_hi_lane"};
    vecs[5]  = '{8'h2C, 32'h0000_ABCD, 4'b0011, 32'h0000_ABCD, "duty3"};
    vecs[6]  = '{8'h40, 32'h0000_1234, 4'b1111, 32'h0000_0000, "ch6_unmapped"};
    vecs[7]  = '{8'h0C, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, "off0c_unmapped"};
    vecs[8]  = '{8'h04, 32'hFFFF_FFFF, 4'b1111, GPIN,          "gpio_in_ro"};
    vecs[9]  = '{8'h30, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, "ch4_unmapped"};
    vecs[10] = '{8'h10, 32'h0000_0000, 4'b0000, 32'h0000_5678, "period0_kept"};
    vecs[11] = '{8'h1C, 32'h00FF_00FF, 4'b0101, 32'h0000_00FF, "duty1_lanes"};
    vecs[12] = '{8'h08, 32'h0000_0000, 4'b1111, 32'h0000_0000, "ctrl_clear"};

    // Reset state
    #12;
    chk("rst_ready", 32'(iomem_ready), 32'd0);
    chk("rst_rdata", iomem_rdata, 32'd0);
    chk("rst_gpio_out", gpio_out, 32'd0);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Register access table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wstrb != 4'b0000) begin
        wr(vecs[i].off, vecs[i].wdata, vecs[i].wstrb);
        if (vecs[i].off == 8'h00) begin
          @(posedge clk);
          #1;
          chk({vecs[i].name, "_pin"}, gpio_out, vecs[i].exp);
        end
      end
      rd_check(vecs[i].off, vecs[i].exp, vecs[i].name);
    end

    // Basic PWM: period 10, 3 high, first high 1 cycle after enable
    wr(8'h10, 32'd9, 4'b1111);
    wr(8'h14, 32'd3, 4'b1111);
    wr(8'h08, 32'd1, 4'b1111);
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      chk("pwm_3of10", 32'(pwm_out), (((k-1) % 10) < 3) ? 32'd1 : 32'd0);
    end
    // Mid-period duty change lands at the boundary after cycle 40
    wr(8'h14, 32'd7, 4'b1111);
    for (int k = 32; k <= 60; k++) begin
      @(posedge clk);
      #1;
      chk("pwm_duty_update", 32'(pwm_out),
          (((k-1) % 10) < (((k-1) >= 40) ? 7 : 3)) ? 32'd1 : 32'd0);
    end

    // Boundary settings
    wr(8'h14, 32'd0, 4'b1111);
    pwm_const(1'b0, 12, 10, "duty0_low");
    wr(8'h14, 32'd10, 4'b1111);
    pwm_const(1'b1, 12, 10, "duty_gt_period");
    wr(8'h10, 32'd0, 4'b1111);
    pwm_const(1'b1, 12, 10, "period0_duty10");
    wr(8'h14, 32'd0, 4'b1111);
    pwm_const(1'b0, 3, 5, "period0_duty0");
    // With period 0 every edge is a boundary: the write edge loads the old duty
    wr(8'h14, 32'd1, 4'b1111);
    @(posedge clk);
    #1;
    chk("coincident_old", 32'(pwm_out), 32'd0);
    @(posedge clk);
    #1;
    chk("coincident_new", 32'(pwm_out), 32'd1);
    pwm_const(1'b1, 0, 8, "period0_duty1");

    // Disable mid-period, then re-enable from cnt=0
    wr(8'h10, 32'd9, 4'b1111);
    wr(8'h14, 32'd10, 4'b1111);
    pwm_const(1'b1, 12, 3, "pre_disable_high");
    wr(8'h08, 32'd0, 4'b1111);
    chk("disable_lag", 32'(pwm_out), 32'd1);
    @(posedge clk);
    #1;
    chk("disable_low", 32'(pwm_out), 32'd0);
    wr(8'h14, 32'd3, 4'b1111);
    wr(8'h08, 32'd1, 4'b1111);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      chk("reenable", 32'(pwm_out), (((k-1) % 10) < 3) ? 32'd1 : 32'd0);
    end

    // Reset with a read pending
    wr(8'h14, 32'd10, 4'b1111);
    pwm_const(1'b1, 12, 4, "pre_reset_high");
    iomem_addr  = BASE + 32'h08;
    iomem_wstrb = 4'b0000;
    iomem_valid = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_async_ready", 32'(iomem_ready), 32'd0);
    chk("rst_async_rdata", iomem_rdata, 32'd0);
    chk("rst_async_gpio", gpio_out, 32'd0);
    chk("rst_async_pwm", 32'(pwm_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_no_ready", 32'(iomem_ready), 32'd0);
    end
    iomem_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    rd_check(8'h08, 32'd0, "ctrl_after_rst");
    rd_check(8'h00, 32'd0, "gpio_after_rst");
    rd_check(8'h14, 32'd0, "duty0_after_rst");

    // Request outside the base address
    wr(8'h00, 32'h0000_0011, 4'b1111);
    iomem_addr  = 32'h0300_0100;
    iomem_wdata = 32'hFFFF_FFFF;
    iomem_wstrb = 4'b1111;
    iomem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("bad_base_no_ready", 32'(iomem_ready), 32'd0);
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    chk("bad_base_gpio", gpio_out, 32'h0000_0011);
    rd_check(8'h00, 32'h0000_0011, "bad_base_gpio_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iomem_pwm_gpio.md
IOMEM_PWM_GPIO -- requirements
Module: iomem_pwm_gpio

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, the number of PWM channels (legal range 1..8).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, the counter, period and duty width in bits (legal range 8..32).
REQ-003 The block SHALL have parameter BASE_ADDR, default 24'h030003, matched against iomem_addr[31:8].
REQ-004 The block SHALL have one clock, clk (input, 1 bit), and all logic SHALL be sequential on its rising edge.
REQ-005 The block SHALL have reset resetn (input, 1 bit), which is asynchronous and active-low.
REQ-006 Ports, as name / direction / width / meaning:
- iomem_valid / in / 1 / bus request.
- iomem_ready / out / 1 / one-cycle completion pulse.
- iomem_wstrb / in / 4 / byte-lane write enables; 0 means read.
- iomem_addr / in / 32 / byte address.
- iomem_wdata / in / 32 / write data.
- iomem_rdata / out / 32 / read data, valid while iomem_ready=1.
- gpio_out / out / 32 / GPIO output register.
- gpio_in / in / 32 / GPIO input pins.
- pwm_out / out / NUM_CH / PWM outputs.

Function
REQ-007 Decode: a request SHALL be selected when iomem_valid=1, iomem_ready=0 and iomem_addr[31:8]==BASE_ADDR; an unselected request SHALL get no response.
REQ-008 Handshake: iomem_ready SHALL be 1 exactly in the cycle after selection and 0 otherwise, so there is one pulse per transaction and never two consecutive cycles.
REQ-009 The register map by offset iomem_addr[7:0] SHALL be:
- 0x00 GPIO_OUT, read/write.
- 0x04 GPIO_IN, read-only, sampled through a 2-flop synchroniser.
- 0x08 CTRL, read/write; bit[ch] is the channel enable.
- 0x10+8*ch PERIOD shadow, read/write.
- 0x14+8*ch DUTY shadow, read/write.
REQ-010 Writes SHALL honour byte lanes independently.
- Bits at or above CNT_WIDTH SHALL be discarded on write and read back as 0.
- CTRL bits at or above NUM_CH SHALL read back as 0.
REQ-011 Reads SHALL return the register value in iomem_rdata in the same cycle as iomem_ready. Registers are not read-to-clear. A read SHALL return shadow values, not active values.
REQ-012 An unmapped offset, or a channel index >= NUM_CH, SHALL still pulse iomem_ready with rdata=0; writes to it SHALL be ignored.
REQ-013 Each channel SHALL hold active_period, active_duty and cnt, all CNT_WIDTH bits wide.
REQ-014 When a channel is disabled:
- cnt=0.
- pwm_out[ch]=0.
- The active registers SHALL be loaded from the shadows every cycle.
REQ-015 When a channel is enabled, cnt SHALL increment each cycle.
- When cnt==active_period, cnt SHALL wrap to 0 on the next cycle and the active registers SHALL load from the shadows at that same edge.
- Shadow writes therefore take effect only at a period boundary, which guarantees glitch-free updates.
REQ-016 pwm_out[ch] SHALL be registered and SHALL equal (cnt < active_duty) of the previous cycle, giving a fixed 1-cycle latency. The period is active_period+1 cycles and the high time is min(active_duty, active_period+1) cycles.
REQ-017 Boundary behaviours:
- duty=0: output constantly low.
- duty > period: output constantly high.
- period=0: cnt stays 0 and the output equals (duty!=0).
- cnt wrap SHALL never exceed active_period, with no overflow, including period = 2^CNT_WIDTH-1.
REQ-018 If a bus write to a shadow coincides with a period-boundary load, the active register SHALL take the old shadow value and the new value SHALL apply at the next boundary.
REQ-019 Clearing an enable bit mid-period SHALL force the output low on the following cycle. Re-enabling SHALL restart from cnt=0 with the current shadows.

Reset
REQ-020 While resetn=0, the following SHALL be 0 asynchronously:
- iomem_ready, iomem_rdata, gpio_out, pwm_out.
- CTRL, all shadows, all active registers, all counters.
- The synchroniser flops.
REQ-021 A reset asserted mid-transaction SHALL abort it with no ready pulse. After release, the first edge SHALL behave as the idle state.

Verification
REQ-022 Write 0xA5 with wstrb=0001 to 0x00, then read 0x00 -> gpio_out=0x000000A5 one cycle after ready; the read returns 0x000000A5; each ready pulse is exactly 1 cycle wide.
REQ-023 With CNT_WIDTH=16: write PERIOD0=9, DUTY0=3, CTRL=1 -> pwm_out[0] repeats 3 cycles high / 7 low, starting 1 cycle after enable.
REQ-024 During that run, write DUTY0=7 mid-period -> the current period keeps 3 high cycles and the next period has 7 high cycles, with no glitch.
REQ-025 Apply boundary settings: DUTY0=0 -> constant low; DUTY0=10 with PERIOD0=9 -> constant high; PERIOD0=0, DUTY0=1 -> constant high; address 0x40 (channel 6 with NUM_CH=4) -> ready pulse with rdata=0.
REQ-026 Drop resetn mid-period with a read pending -> all outputs go to 0 immediately and no ready pulse occurs; after release, a read of 0x08 returns 0.
REQ-027 Issue a request with iomem_addr[31:8]=0x030001 -> no ready pulse within 4 cycles and no register change.
